// File: rtl/stage3_ex_mdu.sv
// MIPS execute stage: ALU, branch-target add, RegDst select and EX/MEM register,
// plus an iterative MULTU/DIVU engine with HI/LO and pipeline valid/stall/flush control.
module stage3_ex_mdu #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  stall_in,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      pc4,
  input  logic                  alusrc,
  input  logic [WIDTH-1:0]      data1,
  input  logic [WIDTH-1:0]      data2,
  input  logic [WIDTH-1:0]      seimm,
  input  logic [1:0]            aluop,
  input  logic [2:0]            md_op,
  input  logic                  regdst,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic [WIDTH-1:0]      pc4_out,
  output logic [WIDTH-1:0]      alurslt,
  output logic                  zero,
  output logic [WIDTH-1:0]      data2_out,
  output logic [REG_ADDR_W-1:0] wrreg_out,
  output logic                  out_valid,
  output logic                  stall_out,
  output logic                  md_busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIVU  = 3'b010;
  localparam logic [2:0] MD_MFHI  = 3'b011;
  localparam logic [2:0] MD_MFLO  = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]        acc_q, acc_d;
  logic [WIDTH-1:0]        wlo_q, wlo_d;
  logic [WIDTH-1:0]        opb_q, opb_d;
  logic [WIDTH-1:0]        hi_q, hi_d;
  logic [WIDTH-1:0]        lo_q, lo_d;
  logic [WIDTH-1:0]        pc4_out_q, pc4_out_d;
  logic [WIDTH-1:0]        alurslt_q, alurslt_d;
  logic                    zero_q, zero_d;
  logic [WIDTH-1:0]        data2_out_q, data2_out_d;
  logic [REG_ADDR_W-1:0]   wrreg_q, wrreg_d;
  logic                    out_valid_q, out_valid_d;

  logic [WIDTH-1:0]        alu_b, alu_sum, alu_diff, res;
  logic [REG_ADDR_W-1:0]   dest;
  logic                    is_start_op, load, start;
  logic [WIDTH:0]          mul_add, div_shift, div_trial;
  logic [WIDTH-1:0]        step_acc, step_wlo;

  assign md_busy     = (state_q != S_IDLE);
  assign stall_out   = stall_in | (in_valid & md_busy & (md_op != 3'b000));
  assign is_start_op = (md_op == MD_MULTU) || (md_op == MD_DIVU);
  assign load        = ~stall_out & ~flush;
  assign start       = load & in_valid & is_start_op;

  // ALU, HI/LO move and destination select
  always_comb begin
    alu_b    = alusrc ? seimm : data2;
    alu_sum  = data1 + alu_b;
    alu_diff = data1 - alu_b;
    res      = alu_sum;
    case (aluop)
      2'b01: res = alu_diff;
      2'b10: begin
        case (seimm[5:0])
          6'h22:   res = alu_diff;
          6'h24:   res = data1 & alu_b;
          6'h25:   res = data1 | alu_b;
          6'h27:   res = ~(data1 | alu_b);
          6'h2A:   res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(alu_b))};
          default: res = alu_sum;
        endcase
      end
      default: res = alu_sum;
    endcase
    dest = regdst ? rd : rt;
    if (md_op == MD_MFHI) begin
      res  = hi_q;
      dest = rd;
    end else if (md_op == MD_MFLO) begin
      res  = lo_q;
      dest = rd;
    end else if (is_start_op) begin
      dest = '0;
    end
  end

  // Next state for EX/MEM register and the mul/div engine
  always_comb begin
    pc4_out_d   = pc4_out_q;
    alurslt_d   = alurslt_q;
    zero_d      = zero_q;
    data2_out_d = data2_out_q;
    wrreg_d     = wrreg_q;
    out_valid_d = out_valid_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    wlo_d       = wlo_q;
    opb_d       = opb_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    step_acc    = acc_q;
    step_wlo    = wlo_q;

    mul_add   = {1'b0, acc_q} + (wlo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, wlo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb_q};

    if (flush)          out_valid_d = 1'b0;
    else if (stall_in)  out_valid_d = out_valid_q;
    else if (stall_out) out_valid_d = 1'b0;
    else                out_valid_d = in_valid;

    if (load) begin
      pc4_out_d   = pc4 + {seimm[WIDTH-3:0], 2'b00};
      alurslt_d   = res;
      zero_d      = (res == '0);
      data2_out_d = data2;
      wrreg_d     = dest;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (md_op == MD_MULTU) ? S_MUL : S_DIV;
          cnt_d   = '0;
          acc_d   = '0;
          wlo_d   = data1;
          opb_d   = data2;
        end
      end
      S_MUL, S_DIV: begin
        if (state_q == S_MUL) begin
          {step_acc, step_wlo} = {mul_add, wlo_q[WIDTH-1:1]};
        end else if (div_shift >= {1'b0, opb_q}) begin
          step_acc = div_trial[WIDTH-1:0];
          step_wlo = {wlo_q[WIDTH-2:0], 1'b1};
        end else begin
          step_acc = div_shift[WIDTH-1:0];
          step_wlo = {wlo_q[WIDTH-2:0], 1'b0};
        end
        acc_d = step_acc;
        wlo_d = step_wlo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_IDLE;
          hi_d    = step_acc;
          lo_d    = step_wlo;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      wlo_q       <= '0;
      opb_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pc4_out_q   <= '0;
      alurslt_q   <= '0;
      zero_q      <= 1'b0;
      data2_out_q <= '0;
      wrreg_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      wlo_q       <= wlo_d;
      opb_q       <= opb_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pc4_out_q   <= pc4_out_d;
      alurslt_q   <= alurslt_d;
      zero_q      <= zero_d;
      data2_out_q <= data2_out_d;
      wrreg_q     <= wrreg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign pc4_out   = pc4_out_q;
  assign alurslt   = alurslt_q;
  assign zero      = zero_q;
  assign data2_out = data2_out_q;
  assign wrreg_out = wrreg_q;
  assign out_valid = out_valid_q;

endmodule
